ballot_unit_ctrl: RTL and testbench

Front-end ballot unit for the voting machine. It conditions raw push-buttons: the presiding officer's ballot-issue and close-poll buttons, plus three candidate buttons. It enforces one vote per issued ballot and drives the single-cycle candidate_ready, vote_candidate_1..3 and voting_session_done strobes consumed by the downstream evm vote-counting FSM. It also provides voter feedback through ballot_led and beep.

---
 rtl/evm_pkg.sv | 40 ++++
 rtl/btn_debounce.sv | 45 ++++
 rtl/ballot_unit_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ballot_unit_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
// Shared types and defaults for the ballot unit front-end.
// Candidate codes match the candidate_name encoding of the evm vote counter.
package evm_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_IDLE,
    ST_ISSUE,
    ST_ARMED,
    ST_CAST,
    ST_BEEP,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    CAND_NONE = 2'b00,
    CAND1     = 2'b01,
    CAND2     = 2'b10,
    CAND3     = 2'b11
  } cand_t;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_BALLOT_TIMEOUT  = 80;
  localparam int DEF_BEEP_CYCLES     = 8;
  localparam int EVM_VOTE_TIMEOUT    = 100;

  function automatic cand_t cand_from_press(input logic [2:0] press);
    case (press)
      3'b001:  return CAND1;
      3'b010:  return CAND2;
      3'b100:  return CAND3;
      default: return CAND_NONE;
    endcase
  endfunction

  function automatic logic [1:0] press_count(input logic [2:0] press);
    return {1'b0, press[0]} + {1'b0, press[1]} + {1'b0, press[2]};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability-counter debouncer and rising-edge press pulse
// for one raw push-button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_stable_q;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_q <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_btn;
      r_sync2    <= r_sync1;
      r_stable_q <= r_stable;
      // Any return to the stable level restarts the stability window.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_stable & ~r_stable_q;

endmodule

// File: rtl/ballot_unit_ctrl.sv
// Ballot unit front-end: debounces officer/candidate buttons, enforces one vote
// per issued ballot and produces single-cycle strobes for the evm counter.
module ballot_unit_ctrl
  import evm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int BALLOT_TIMEOUT  = DEF_BALLOT_TIMEOUT,
  parameter int BEEP_CYCLES     = DEF_BEEP_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       switch_on_evm,
  input  logic       btn_ballot,
  input  logic       btn_close,
  input  logic [2:0] btn_cand,
  output logic       candidate_ready,
  output logic       vote_candidate_1,
  output logic       vote_candidate_2,
  output logic       vote_candidate_3,
  output logic       voting_session_done,
  output logic       ballot_led,
  output logic       beep,
  output logic       vote_rejected,
  output logic       ballot_expired
);

  localparam int TW = $clog2(BALLOT_TIMEOUT + 1);
  localparam int BW = $clog2(BEEP_CYCLES + 1);

  if (BALLOT_TIMEOUT < 1 || BALLOT_TIMEOUT >= EVM_VOTE_TIMEOUT) begin : g_bad_timeout
    $error("BALLOT_TIMEOUT must be in 1..EVM_VOTE_TIMEOUT-1");
  end
  if (DEBOUNCE_CYCLES < 2 || BEEP_CYCLES < 1) begin : g_bad_params
    $error("DEBOUNCE_CYCLES must be >= 2 and BEEP_CYCLES >= 1");
  end

  // Button order: 0 = ballot, 1 = close, 2..4 = candidates 1..3.
  logic [4:0] w_raw;
  logic [4:0] w_press;
  assign w_raw = {btn_cand, btn_close, btn_ballot};

  genvar gi;
  for (gi = 0; gi < 5; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (w_raw[gi]),
      .o_press(w_press[gi])
    );
  end

  logic       w_press_ballot;
  logic       w_press_close;
  logic [2:0] w_press_cand;
  logic [1:0] w_npress;
  assign w_press_ballot = w_press[0];
  assign w_press_close  = w_press[1];
  assign w_press_cand   = w_press[4:2];
  assign w_npress       = press_count(w_press_cand);

  state_t        r_state,      w_state_next;
  logic [TW-1:0] r_timer,      w_timer_next;
  logic [BW-1:0] r_beep_cnt,   w_beep_next;
  cand_t         r_sel,        w_sel_next;
  logic          r_rejected,   w_rejected_next;
  logic          r_expired,    w_expired_next;
  logic          r_done_first, w_done_first_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_OFF;
      r_timer      <= '0;
      r_beep_cnt   <= '0;
      r_sel        <= CAND_NONE;
      r_rejected   <= 1'b0;
      r_expired    <= 1'b0;
      r_done_first <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_timer      <= w_timer_next;
      r_beep_cnt   <= w_beep_next;
      r_sel        <= w_sel_next;
      r_rejected   <= w_rejected_next;
      r_expired    <= w_expired_next;
      r_done_first <= w_done_first_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_timer_next      = r_timer;
    w_beep_next       = r_beep_cnt;
    w_sel_next        = r_sel;
    w_rejected_next   = 1'b0;
    w_expired_next    = 1'b0;
    w_done_first_next = 1'b0;
    if (!switch_on_evm) begin
      w_state_next = ST_OFF;
      w_timer_next = '0;
      w_beep_next  = '0;
      w_sel_next   = CAND_NONE;
    end else begin
      case (r_state)
        ST_OFF:  w_state_next = ST_IDLE;
        ST_IDLE: begin
          if (w_press_ballot) begin
            w_state_next = ST_ISSUE;
          end else if (w_press_close) begin
            w_state_next      = ST_DONE;
            w_done_first_next = 1'b1;
          end
        end
        ST_ISSUE: begin
          w_state_next = ST_ARMED;
          w_timer_next = '0;
        end
        ST_ARMED: begin
          // A single valid press beats a timeout landing in the same cycle.
          if (w_npress == 2'd1) begin
            w_sel_next   = cand_from_press(w_press_cand);
            w_state_next = ST_CAST;
          end else begin
            w_rejected_next = (w_npress >= 2'd2);
            if (r_timer == TW'(BALLOT_TIMEOUT - 1)) begin
              w_state_next   = ST_IDLE;
              w_expired_next = 1'b1;
            end else begin
              w_timer_next = r_timer + TW'(1);
            end
          end
        end
        ST_CAST: begin
          w_state_next = ST_BEEP;
          w_beep_next  = '0;
        end
        ST_BEEP: begin
          if (r_beep_cnt == BW'(BEEP_CYCLES - 1)) begin
            w_state_next = ST_IDLE;
            w_beep_next  = '0;
          end else begin
            w_beep_next = r_beep_cnt + BW'(1);
          end
        end
        ST_DONE: w_state_next = ST_DONE;
        default: w_state_next = ST_OFF;
      endcase
    end
  end

  assign candidate_ready     = (r_state == ST_ISSUE);
  assign vote_candidate_1    = (r_state == ST_CAST) && (r_sel == CAND1);
  assign vote_candidate_2    = (r_state == ST_CAST) && (r_sel == CAND2);
  assign vote_candidate_3    = (r_state == ST_CAST) && (r_sel == CAND3);
  assign voting_session_done = (r_state == ST_DONE) && r_done_first;
  assign ballot_led          = (r_state == ST_ARMED);
  assign beep                = (r_state == ST_BEEP);
  assign vote_rejected       = r_rejected;
  assign ballot_expired      = r_expired;

endmodule

// File: tb/tb_ballot_unit_ctrl.sv
// Directed bench for ballot_unit_ctrl with short debounce/timeout/beep settings;
// expected output vectors are worked out by hand from the cycle timing.
module tb_ballot_unit_ctrl;

  localparam int DB = 4;
  localparam int BT = 20;
  localparam int BC = 3;

  // Output vector bit order: rdy v1 v2 v3 done led beep rej exp
  localparam logic [8:0] O_NONE = 9'b0_0000_0000;
  localparam logic [8:0] O_RDY  = 9'b1_0000_0000;
  localparam logic [8:0] O_V2   = 9'b0_0100_0000;
  localparam logic [8:0] O_DONE = 9'b0_0001_0000;
  localparam logic [8:0] O_LED  = 9'b0_0000_1000;
  localparam logic [8:0] O_BEEP = 9'b0_0000_0100;
  localparam logic [8:0] O_REJ  = 9'b0_0000_0010;
  localparam logic [8:0] O_EXP  = 9'b0_0000_0001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       switch_on_evm = 1'b0;
  logic       btn_ballot = 1'b0;
  logic       btn_close = 1'b0;
  logic [2:0] btn_cand = 3'b000;
  logic       candidate_ready, vote_candidate_1, vote_candidate_2, vote_candidate_3;
  logic       voting_session_done, ballot_led, beep, vote_rejected, ballot_expired;
  logic [8:0] w_outs;

  int n_checks = 0;
  int n_errors = 0;
  int cnt[9];

  always #5 clk = ~clk;

  ballot_unit_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .BALLOT_TIMEOUT (BT),
    .BEEP_CYCLES    (BC)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .switch_on_evm      (switch_on_evm),
    .btn_ballot         (btn_ballot),
    .btn_close          (btn_close),
    .btn_cand           (btn_cand),
    .candidate_ready    (candidate_ready),
    .vote_candidate_1   (vote_candidate_1),
    .vote_candidate_2   (vote_candidate_2),
    .vote_candidate_3   (vote_candidate_3),
    .voting_session_done(voting_session_done),
    .ballot_led         (ballot_led),
    .beep               (beep),
    .vote_rejected      (vote_rejected),
    .ballot_expired     (ballot_expired)
  );

  assign w_outs = {candidate_ready, vote_candidate_1, vote_candidate_2, vote_candidate_3,
                   voting_session_done, ballot_led, beep, vote_rejected, ballot_expired};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[tb] ok   %s = %0h", tag, got);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Count the cycles each output is high over a window of n cycles.
  task automatic watch(input int n);
    for (int b = 0; b < 9; b++) cnt[b] = 0;
    repeat (n) begin
      @(negedge clk);
      for (int b = 0; b < 9; b++) if (w_outs[b]) cnt[b]++;
    end
  endtask

  function automatic int total_pulses();
    int s = 0;
    for (int b = 0; b < 9; b++) s += cnt[b];
    return s;
  endfunction

  // Press ballot from IDLE; returns on the first ARMED cycle with the button released.
  task automatic issue_ballot(input string tag);
    btn_ballot = 1'b1;
    ticks(DB + 2);
    chk({tag, "_pre"}, w_outs, O_NONE);
    ticks(1);
    chk({tag, "_rdy"}, w_outs, O_RDY);
    ticks(1);
    chk({tag, "_led"}, w_outs, O_LED);
    btn_ballot = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    switch_on_evm = 1'b1;
    ticks(2);
    chk("reset_outs", w_outs, O_NONE);
    rst = 1'b1;
    ticks(3);

    $display("[tb] test 1: ballot then vote for candidate 2");
    issue_ballot("t1");
    btn_cand = 3'b010;
    ticks(6);
    chk("t1_armed", w_outs, O_LED);
    ticks(1);
    chk("t1_vote2", w_outs, O_V2);
    for (int i = 0; i < BC; i++) begin
      ticks(1);
      chk("t1_beep", w_outs, O_BEEP);
    end
    ticks(1);
    chk("t1_idle", w_outs, O_NONE);
    btn_cand = 3'b000;
    ticks(10);

    $display("[tb] test 2: bouncy candidate 1 button");
    issue_ballot("t2");
    for (int i = 0; i < 3; i++) begin
      btn_cand[0] = 1'b1;
      ticks(2);
      btn_cand[0] = 1'b0;
      ticks(2);
    end
    btn_cand[0] = 1'b1;
    watch(15);
    chk("t2_v1_count", cnt[7], 1);
    chk("t2_other_count", cnt[6] + cnt[5] + cnt[1] + cnt[0], 0);
    chk("t2_beep_count", cnt[2], BC);
    btn_cand = 3'b000;
    ticks(10);

    $display("[tb] test 3: double press rejected, then candidate 3");
    issue_ballot("t3");
    btn_cand = 3'b101;
    ticks(7);
    chk("t3_rejected", w_outs, O_LED | O_REJ);
    ticks(1);
    chk("t3_still_armed", w_outs, O_LED);
    btn_cand = 3'b000;
    ticks(4);
    btn_cand = 3'b100;
    watch(12);
    chk("t3_v3_count", cnt[5], 1);
    chk("t3_other_count", cnt[7] + cnt[6] + cnt[1] + cnt[0], 0);
    btn_cand = 3'b000;
    ticks(10);

    $display("[tb] test 4: armed ballot times out");
    issue_ballot("t4");
    ticks(BT - 1);
    chk("t4_last_armed", w_outs, O_LED);
    ticks(1);
    chk("t4_expired", w_outs, O_EXP);
    ticks(1);
    chk("t4_idle", w_outs, O_NONE);
    btn_cand = 3'b010;
    watch(12);
    chk("t4_no_vote", total_pulses(), 0);
    btn_cand = 3'b000;
    ticks(10);

    $display("[tb] test 5: close poll, power cycle, reopen");
    btn_close = 1'b1;
    ticks(DB + 2);
    chk("t5_pre", w_outs, O_NONE);
    ticks(1);
    chk("t5_done", w_outs, O_DONE);
    ticks(1);
    chk("t5_done_hold", w_outs, O_NONE);
    btn_close = 1'b0;
    btn_ballot = 1'b1;
    btn_cand = 3'b001;
    watch(12);
    chk("t5_locked", total_pulses(), 0);
    btn_ballot = 1'b0;
    btn_cand = 3'b000;
    switch_on_evm = 1'b0;
    ticks(1);
    chk("t5_off", w_outs, O_NONE);
    ticks(10);
    switch_on_evm = 1'b1;
    ticks(1);
    issue_ballot("t5_again");

    $display("[tb] test 6: async reset while armed and while beeping");
    ticks(2);
    chk("t6_armed", w_outs, O_LED);
    rst = 1'b0;
    #1;
    chk("t6_rst_armed", w_outs, O_NONE);
    ticks(2);
    rst = 1'b1;
    ticks(3);
    issue_ballot("t6b");
    btn_cand = 3'b010;
    ticks(8);
    chk("t6_beep", w_outs, O_BEEP);
    rst = 1'b0;
    #1;
    chk("t6_rst_beep", w_outs, O_NONE);
    ticks(2);
    rst = 1'b1;
    watch(20);
    chk("t6_quiet", total_pulses(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
